// File: rtl/id_ex_stage_pkg.sv
// Shared constants and FSM encoding for the dual-issue ID/EX stage.
package id_ex_stage_pkg;

    localparam int NUM_REGISTERS_LOG2 = 5;

    typedef enum logic {
        ID_EX_ISSUE = 1'b0,
        ID_EX_SPLIT = 1'b1
    } id_ex_state_t;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Combinational hazard detection: load-use per decode lane against both ID/EX
// slots, and lane1-on-lane0 dependency inside one decode bundle.
module id_ex_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_W = NUM_REGISTERS_LOG2
) (
    input  logic             dec_valid0,
    input  logic             dec_valid1,
    input  logic [REG_W-1:0] dec_rs0,
    input  logic [REG_W-1:0] dec_rt0,
    input  logic             dec_uses_rt0,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rt1,
    input  logic             dec_uses_rt1,
    input  logic [REG_W-1:0] dec_rd0,
    input  logic             dec_reg_write0,
    input  logic             ex_valid0,
    input  logic             ex_mem_read0,
    input  logic [REG_W-1:0] ex_rd0,
    input  logic             ex_valid1,
    input  logic             ex_mem_read1,
    input  logic [REG_W-1:0] ex_rd1,
    output logic             load_use0,
    output logic             load_use1,
    output logic             intra_dep
);

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reads_reg(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt,
                                       input logic             uses_rt);
        return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    logic ld_slot0;
    logic ld_slot1;

    assign ld_slot0 = ex_valid0 && ex_mem_read0;
    assign ld_slot1 = ex_valid1 && ex_mem_read1;

    assign load_use0 = dec_valid0 &&
                       ((ld_slot0 && reads_reg(ex_rd0, dec_rs0, dec_rt0, dec_uses_rt0)) ||
                        (ld_slot1 && reads_reg(ex_rd1, dec_rs0, dec_rt0, dec_uses_rt0)));

    assign load_use1 = dec_valid1 &&
                       ((ld_slot0 && reads_reg(ex_rd0, dec_rs1, dec_rt1, dec_uses_rt1)) ||
                        (ld_slot1 && reads_reg(ex_rd1, dec_rs1, dec_rt1, dec_uses_rt1)));

    assign intra_dep = dec_valid0 && dec_valid1 && dec_reg_write0 &&
                       reads_reg(dec_rd0, dec_rs1, dec_rt1, dec_uses_rt1);

endmodule

// File: rtl/id_ex_stage.sv
// Dual-issue ID/EX pipeline register with load-use bubbling, bundle
// splitting, EX hold and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_W      = NUM_REGISTERS_LOG2,
    parameter int CTRL_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  ex_hold,
    input  logic                  if_id_valid0,
    input  logic                  if_id_valid1,
    input  logic [REG_W-1:0]      if_id_rs0,
    input  logic [REG_W-1:0]      if_id_rs1,
    input  logic [REG_W-1:0]      if_id_rt0,
    input  logic [REG_W-1:0]      if_id_rt1,
    input  logic                  if_id_uses_rt0,
    input  logic                  if_id_uses_rt1,
    input  logic [REG_W-1:0]      if_id_rd0,
    input  logic [REG_W-1:0]      if_id_rd1,
    input  logic                  if_id_reg_write0,
    input  logic                  if_id_reg_write1,
    input  logic                  if_id_mem_read0,
    input  logic                  if_id_mem_read1,
    input  logic [CTRL_W-1:0]     if_id_ctrl0,
    input  logic [CTRL_W-1:0]     if_id_ctrl1,
    input  logic [DATA_WIDTH-1:0] if_id_rs_data0,
    input  logic [DATA_WIDTH-1:0] if_id_rs_data1,
    input  logic [DATA_WIDTH-1:0] if_id_rt_data0,
    input  logic [DATA_WIDTH-1:0] if_id_rt_data1,
    output logic                  stall,
    output logic                  id_ex_valid0,
    output logic                  id_ex_valid1,
    output logic [REG_W-1:0]      id_ex_rs0,
    output logic [REG_W-1:0]      id_ex_rs1,
    output logic [REG_W-1:0]      id_ex_rt0,
    output logic [REG_W-1:0]      id_ex_rt1,
    output logic [REG_W-1:0]      id_ex_rd0,
    output logic [REG_W-1:0]      id_ex_rd1,
    output logic                  id_ex_reg_write0,
    output logic                  id_ex_reg_write1,
    output logic                  id_ex_mem_read0,
    output logic                  id_ex_mem_read1,
    output logic [CTRL_W-1:0]     id_ex_ctrl0,
    output logic [CTRL_W-1:0]     id_ex_ctrl1,
    output logic [DATA_WIDTH-1:0] id_ex_rs_data0,
    output logic [DATA_WIDTH-1:0] id_ex_rs_data1,
    output logic [DATA_WIDTH-1:0] id_ex_rt_data0,
    output logic [DATA_WIDTH-1:0] id_ex_rt_data1
);

    typedef struct packed {
        logic                  valid;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic [REG_W-1:0]      rd;
        logic                  reg_write;
        logic                  mem_read;
        logic [CTRL_W-1:0]     ctrl;
        logic [DATA_WIDTH-1:0] rs_data;
        logic [DATA_WIDTH-1:0] rt_data;
    } slot_t;

    id_ex_state_t state_q;
    id_ex_state_t state_nxt;
    slot_t        lane0_p0;
    slot_t        lane1_p0;
    slot_t        slot0_p1;
    slot_t        slot1_p1;
    slot_t        slot0_nxt;
    slot_t        slot1_nxt;
    logic         stall_raw;
    logic         load_use0;
    logic         load_use1;
    logic         intra_dep;

    // ---- decode (p0): an invalid lane is already a bubble here ----
    always_comb begin
        lane0_p0 = '0;
        lane1_p0 = '0;
        if (if_id_valid0) begin
            lane0_p0 = '{1'b1, if_id_rs0, if_id_rt0, if_id_rd0, if_id_reg_write0,
                         if_id_mem_read0, if_id_ctrl0, if_id_rs_data0, if_id_rt_data0};
        end
        if (if_id_valid1) begin
            lane1_p0 = '{1'b1, if_id_rs1, if_id_rt1, if_id_rd1, if_id_reg_write1,
                         if_id_mem_read1, if_id_ctrl1, if_id_rs_data1, if_id_rt_data1};
        end
    end

    id_ex_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .dec_valid0    (if_id_valid0),
        .dec_valid1    (if_id_valid1),
        .dec_rs0       (if_id_rs0),
        .dec_rt0       (if_id_rt0),
        .dec_uses_rt0  (if_id_uses_rt0),
        .dec_rs1       (if_id_rs1),
        .dec_rt1       (if_id_rt1),
        .dec_uses_rt1  (if_id_uses_rt1),
        .dec_rd0       (if_id_rd0),
        .dec_reg_write0(if_id_reg_write0),
        .ex_valid0     (slot0_p1.valid),
        .ex_mem_read0  (slot0_p1.mem_read),
        .ex_rd0        (slot0_p1.rd),
        .ex_valid1     (slot1_p1.valid),
        .ex_mem_read1  (slot1_p1.mem_read),
        .ex_rd1        (slot1_p1.rd),
        .load_use0     (load_use0),
        .load_use1     (load_use1),
        .intra_dep     (intra_dep)
    );

    // In SPLIT, slot1 is always a bubble, so load_use1 reduces to lane1 vs slot0.
    always_comb begin
        state_nxt = state_q;
        slot0_nxt = slot0_p1;
        slot1_nxt = slot1_p1;
        stall_raw = 1'b0;
        if (flush) begin
            slot0_nxt = '0;
            slot1_nxt = '0;
            state_nxt = ID_EX_ISSUE;
        end else if (ex_hold) begin
            stall_raw = 1'b1;
        end else begin
            case (state_q)
                ID_EX_ISSUE: begin
                    if (load_use0 || load_use1) begin
                        slot0_nxt = '0;
                        slot1_nxt = '0;
                        stall_raw = 1'b1;
                    end else if (intra_dep) begin
                        slot0_nxt = lane0_p0;
                        slot1_nxt = '0;
                        stall_raw = 1'b1;
                        state_nxt = ID_EX_SPLIT;
                    end else begin
                        slot0_nxt = lane0_p0;
                        slot1_nxt = lane1_p0;
                    end
                end
                ID_EX_SPLIT: begin
                    if (load_use1) begin
                        slot0_nxt = '0;
                        slot1_nxt = '0;
                        stall_raw = 1'b1;
                    end else begin
                        slot0_nxt = '0;
                        slot1_nxt = lane1_p0;
                        state_nxt = ID_EX_ISSUE;
                    end
                end
                default: state_nxt = ID_EX_ISSUE;
            endcase
        end
    end

    // Reset forces the front end free-running while the stage is empty.
    assign stall = reset_n && stall_raw;

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ID_EX_ISSUE;
            slot0_p1 <= '0;
            slot1_p1 <= '0;
        end else begin
            state_q  <= state_nxt;
            slot0_p1 <= slot0_nxt;
            slot1_p1 <= slot1_nxt;
        end
    end

    assign id_ex_valid0     = slot0_p1.valid;
    assign id_ex_valid1     = slot1_p1.valid;
    assign id_ex_rs0        = slot0_p1.rs;
    assign id_ex_rs1        = slot1_p1.rs;
    assign id_ex_rt0        = slot0_p1.rt;
    assign id_ex_rt1        = slot1_p1.rt;
    assign id_ex_rd0        = slot0_p1.rd;
    assign id_ex_rd1        = slot1_p1.rd;
    assign id_ex_reg_write0 = slot0_p1.reg_write;
    assign id_ex_reg_write1 = slot1_p1.reg_write;
    assign id_ex_mem_read0  = slot0_p1.mem_read;
    assign id_ex_mem_read1  = slot1_p1.mem_read;
    assign id_ex_ctrl0      = slot0_p1.ctrl;
    assign id_ex_ctrl1      = slot1_p1.ctrl;
    assign id_ex_rs_data0   = slot0_p1.rs_data;
    assign id_ex_rs_data1   = slot1_p1.rs_data;
    assign id_ex_rt_data0   = slot0_p1.rt_data;
    assign id_ex_rt_data1   = slot1_p1.rt_data;

endmodule
